// File: rtl/block_mover_pkg.sv
// Shared constants and types for the block_mover animation slice.
package block_mover_pkg;

   localparam logic [3:0] CMD_BLACK    = 4'hF;
   localparam int         BLOCK_SIZE   = 4;
   localparam logic [2:0] COLOUR_BLACK = 3'b000;

   // VGA adapter port widths at 160x120.
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ERASE,
      ST_MOVE,
      ST_DRAW
   } state_t;

endpackage : block_mover_pkg

// File: rtl/block_mover_if.sv
// VGA adapter pixel-write port: one pixel per clock when plot is high.
interface block_mover_if;
   import block_mover_pkg::*;

   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [C_W-1:0] colour;
   logic           plot;

   modport master (output x, y, colour, plot);
   modport slave  (input  x, y, colour, plot);

endinterface : block_mover_if

// File: rtl/block_mover_pixel_sweep.sv
// 4x4 raster sweep counter: dx runs fastest, done flags the last pixel.
module pixel_sweep
   import block_mover_pkg::*;
(
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   input  logic       active,
   output logic [1:0] dx,
   output logic [1:0] dy,
   output logic       done
);

   localparam logic [3:0] LAST_PIXEL = 4'(BLOCK_SIZE * BLOCK_SIZE - 1);

   logic [3:0] cnt;

   // Counter clears on start and advances one pixel per active cycle.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
      if (!reset)
         cnt <= '0;
      else if (start)
         cnt <= '0;
      else if (active)
         cnt <= cnt + 4'd1;
   end

   assign dx   = cnt[1:0];
   assign dy   = cnt[3:2];
   assign done = active && (cnt == LAST_PIXEL);

endmodule : pixel_sweep

// File: rtl/block_mover.sv
// Per-frame erase / step-left / redraw of a 4x4 block on the VGA pixel port.
module block_mover
   import block_mover_pkg::*;
#(
   parameter int unsigned X_START = 156,
   parameter int unsigned X_END   = 0,
   parameter int unsigned STEP    = 1,
   parameter int unsigned Y_ROW   = 60,
   parameter logic [2:0]  COLOUR  = 3'b100
)(
   input  logic           CLK,
   input  logic           reset,
   input  logic [3:0]     command,
   input  logic           enable,
   block_mover_if.master  vga,
   output logic           busy
);

   localparam logic [X_W-1:0] X_START_V  = X_W'(X_START);
   localparam logic [X_W-1:0] STEP_V     = X_W'(STEP);
   localparam logic [Y_W-1:0] Y_ROW_V    = Y_W'(Y_ROW);
   // x_pos - STEP is negative or below X_END exactly when x_pos < STEP + X_END.
   localparam logic [X_W:0]   WRAP_BELOW = (X_W+1)'(STEP + X_END);

   state_t         state;
   state_t         state_nx;
   logic [3:0]     prev_cmd;
   logic           frame_start;
   logic [X_W-1:0] x_pos;
   logic           sweep_start;
   logic           sweep_active;
   logic           sweep_done;
   logic [1:0]     dx;
   logic [1:0]     dy;

   // Remember last command so a frame fires only on the entry into Black.
   always_ff @(posedge CLK) begin
      if (!reset)
         prev_cmd <= 4'h0;
      else
         prev_cmd <= command;
   end

   assign frame_start = (command == CMD_BLACK) && (prev_cmd != CMD_BLACK) && enable;

   // State register.
   always_ff @(posedge CLK) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; a trigger outside IDLE is simply dropped.
   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch is inferred.
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (frame_start) state_nx = ST_ERASE;
         ST_ERASE: if (sweep_done)  state_nx = ST_MOVE;
         ST_MOVE:                   state_nx = ST_DRAW;
         ST_DRAW:  if (sweep_done)  state_nx = ST_IDLE;
         default:                   state_nx = ST_IDLE;
      endcase
   end

   assign sweep_start  = ((state == ST_IDLE) && frame_start) || (state == ST_MOVE);
   assign sweep_active = (state == ST_ERASE) || (state == ST_DRAW);

   pixel_sweep u_sweep (
      .CLK    (CLK),
      .reset  (reset),
      .start  (sweep_start),
      .active (sweep_active),
      .dx     (dx),
      .dy     (dy),
      .done   (sweep_done)
   );

   // Step the block left once per frame, wrapping back to X_START at the edge.
   always_ff @(posedge CLK) begin
      if (!reset)
         x_pos <= X_START_V;
      else if (state == ST_MOVE) begin
         if ({1'b0, x_pos} < WRAP_BELOW)
            x_pos <= X_START_V;
         else
            x_pos <= x_pos - STEP_V;
      end
   end

   // Output decode straight from state, sweep position and x_pos.
   always_comb begin
      vga.plot   = 1'b0;
      vga.colour = COLOUR_BLACK;
      vga.x      = x_pos;
      vga.y      = Y_ROW_V;
      unique case (state)
         ST_ERASE: begin
            vga.plot   = 1'b1;
            vga.colour = COLOUR_BLACK;
            vga.x      = x_pos + {6'b0, dx};
            vga.y      = Y_ROW_V + {5'b0, dy};
         end
         ST_DRAW: begin
            vga.plot   = 1'b1;
            vga.colour = COLOUR;
            vga.x      = x_pos + {6'b0, dx};
            vga.y      = Y_ROW_V + {5'b0, dy};
         end
         default: ;
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule : block_mover

// File: tb/tb_block_mover.sv
// Scoreboard bench for block_mover: stimulus pushes expected pixels, monitor pops on plot.
module tb_block_mover;

   localparam int X_START = 156;
   localparam int X_END   = 0;
   localparam int STEP    = 1;
   localparam int Y_ROW   = 60;
   localparam logic [2:0] COLOUR = 3'b100;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       CLK;
   logic       reset;
   logic [3:0] command;
   logic       enable;
   logic       busy;

   block_mover_if vga ();

   block_mover #(
      .X_START (X_START),
      .X_END   (X_END),
      .STEP    (STEP),
      .Y_ROW   (Y_ROW),
      .COLOUR  (COLOUR)
   ) dut (
      .CLK     (CLK),
      .reset   (reset),
      .command (command),
      .enable  (enable),
      .vga     (vga.master),
      .busy    (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   total;
   int   bad;
   int   plot_count;
   int   pos;
   pix_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every plotted pixel must match the head of the expected queue.
   initial begin
      plot_count = 0;
      forever begin
         @(negedge CLK);
         if (vga.plot === 1'b1) begin
            pix_t got;
            plot_count++;
            got = '{x: vga.x, y: vga.y, c: vga.colour};
            if (exp_q.size() == 0)
               check("unexpected_plot", 32'(got), 32'h0);
            else
               check("pixel", 32'(got), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected raster of a 4x4 block: dx fastest, then dy.
   task automatic push_block(input int px, input logic [2:0] c, input int count);
      for (int i = 0; i < count; i++)
         exp_q.push_back('{x: 8'(px + (i % 4)), y: 7'(Y_ROW + (i / 4)), c: c});
   endtask

   function automatic int next_pos(input int p);
      int d;
      d = p - STEP;
      if (d < 0 || d < X_END) return X_START;
      return d;
   endfunction

   // One full frame from a fresh Black edge, checking final position.
   task automatic do_frame();
      int np;
      command = 4'h0;
      tick();
      np = next_pos(pos);
      push_block(pos, 3'b000, 16);
      push_block(np, COLOUR, 16);
      command = 4'hF;
      repeat (34) tick();
      check("frame_busy_end", 32'(busy), 32'h0);
      check("frame_x_pos", 32'(vga.x), 32'(np));
      pos = np;
   endtask

   initial begin
      int base;
      total   = 0;
      bad     = 0;
      pos     = X_START;
      reset   = 1'b0;
      command = 4'hF;
      enable  = 1'b1;

      // Reset held with command at Black.
      repeat (3) tick();
      check("rst_plot", 32'(vga.plot), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_x", 32'(vga.x), 32'd156);
      check("rst_y", 32'(vga.y), 32'd60);
      check("rst_colour", 32'(vga.colour), 32'h0);
      reset   = 1'b1;
      command = 4'h0;
      repeat (5) tick();
      check("post_rst_idle", 32'(busy), 32'h0);

      // Single frame with detailed timing, then Black held for a full interval.
      for (int i = 0; i < 15; i++) begin
         command = 4'(i);
         tick();
      end
      base = plot_count;
      push_block(156, 3'b000, 16);
      push_block(155, COLOUR, 16);
      command = 4'hF;
      tick();                                   // just after edge T
      check("t1_plot", 32'(vga.plot), 32'h1);
      check("t1_busy", 32'(busy), 32'h1);
      check("t1_x", 32'(vga.x), 32'd156);
      check("t1_colour", 32'(vga.colour), 32'h0);
      repeat (15) tick();
      check("t16_plot", 32'(vga.plot), 32'h1);
      check("t16_x", 32'(vga.x), 32'd159);
      check("t16_y", 32'(vga.y), 32'd63);
      tick();
      check("move_plot", 32'(vga.plot), 32'h0);
      check("move_busy", 32'(busy), 32'h1);
      tick();
      check("draw_plot", 32'(vga.plot), 32'h1);
      check("draw_x", 32'(vga.x), 32'd155);
      check("draw_colour", 32'(vga.colour), 32'(COLOUR));
      repeat (15) tick();
      check("t33_busy", 32'(busy), 32'h1);
      tick();
      check("t34_busy", 32'(busy), 32'h0);
      check("t34_plot", 32'(vga.plot), 32'h0);
      check("t34_x", 32'(vga.x), 32'd155);
      repeat (19201 - 34) tick();
      check("held_black_plots", 32'(plot_count - base), 32'd32);
      pos = 155;

      // Second Black edge while busy is dropped.
      command = 4'h0;
      tick();
      base = plot_count;
      push_block(155, 3'b000, 16);
      push_block(154, COLOUR, 16);
      command = 4'hF;
      tick();
      repeat (3) tick();
      command = 4'h3;
      tick();
      command = 4'hF;
      tick();
      repeat (28) tick();
      check("busy_trig_end", 32'(busy), 32'h0);
      check("busy_trig_x", 32'(vga.x), 32'd154);
      repeat (40) tick();
      check("busy_trig_idle", 32'(busy), 32'h0);
      check("busy_trig_plots", 32'(plot_count - base), 32'd32);
      pos = 154;

      // Disabled: a Black edge must not start a frame.
      enable  = 1'b0;
      command = 4'h0;
      tick();
      base = plot_count;
      command = 4'hF;
      tick();
      check("dis_busy", 32'(busy), 32'h0);
      repeat (40) tick();
      check("dis_busy_late", 32'(busy), 32'h0);
      check("dis_plots", 32'(plot_count - base), 32'd0);
      check("dis_x", 32'(vga.x), 32'd154);
      command = 4'h0;
      tick();
      enable = 1'b1;

      // Walk down to x_pos=0, then one more frame wraps to X_START.
      while (pos != 0) do_frame();
      check("at_zero", 32'(vga.x), 32'd0);
      do_frame();
      check("wrapped", 32'(vga.x), 32'd156);

      // Reset sampled at T+10: ten erase pixels, then clean idle.
      command = 4'h0;
      tick();
      push_block(156, 3'b000, 10);
      command = 4'hF;
      tick();
      repeat (9) tick();
      reset = 1'b0;
      tick();
      check("midrst_plot", 32'(vga.plot), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_x", 32'(vga.x), 32'd156);
      reset   = 1'b1;
      command = 4'h0;
      repeat (5) tick();
      check("midrst_after", 32'(busy), 32'h0);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_block_mover

// File: doc/block_mover.md
# block_mover

Downstream consumer of the draw sequencer's 4-bit `command` stream. Detects the start of each Black (idle) interval, which marks one animation frame. On each frame it erases a 4x4 block at its current position, steps it left, and redraws it. Drives the VGA adapter pixel-write port (x, y, colour, plot) at 160x120, one pixel per clock.

## Interface
- `X_START`, default 156: x position after reset and after wrap; must be ≤ 156.
- `X_END`, default 0: leftmost allowed x position.
- `STEP`, default 1: pixels moved left per frame, 1..15.
- `Y_ROW`, default 60: top row of block; must be ≤ 116.
- `COLOUR`, default 3'b100: draw colour.
- `CLK`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `command`  in  4  sequencer command; 4'hF = Black/idle, 4'h0..4'hE = draw steps.
- `enable`  in  1  when 0, frame triggers are ignored and the block holds its position.
- `x`  out  8  pixel x to VGA adapter.
- `y`  out  7  pixel y to VGA adapter.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  high while a frame update is in progress.

## Operation
- Registered `prev_cmd` (reset 4'h0).
- `frame_start` = (command == 4'hF) && (prev_cmd != 4'hF) && enable.
- Only `frame_start` matters. Values 4'h0..4'hE are otherwise ignored.
- FSM states: IDLE, ERASE, MOVE, DRAW.
- IDLE: on `frame_start`, go to ERASE with cnt=0. Otherwise stay in IDLE.
- ERASE: plot=1, colour=3'b000, x = x_pos + cnt[1:0], y = Y_ROW + cnt[3:2]. cnt increments each cycle. After cnt=15, go to MOVE.
- MOVE: plot=0. Compute 9-bit diff = x_pos − STEP. If diff is negative or < X_END, x_pos ← X_START; else x_pos ← diff. Go to DRAW with cnt=0.
- DRAW: same sweep as ERASE with colour=COLOUR at the new x_pos. After cnt=15, go to IDLE.
- `busy` = (state != IDLE).
- `frame_start` while busy is dropped, not queued. `prev_cmd` still updates every cycle.
- In IDLE, outputs are: plot=0, colour=0, x=x_pos, y=Y_ROW.
- Reset values: state=IDLE, cnt=0, x_pos=X_START, prev_cmd=0, plot=0, busy=0, colour=0.
- Reset mid-frame takes effect at the next edge. No partial pixel is written after reset is sampled. A half-drawn block remaining on screen is acceptable.
- The first frame after reset erases at X_START. This is harmless.
- Arithmetic: x_pos is 8-bit unsigned. Sweep adds are 8-bit and 7-bit with no overflow, guaranteed by the parameter limits.

## Timing
- `x`, `y`, `colour`, `plot` and `busy` are decoded combinationally from registered state, cnt and x_pos. No extra output register.
- `frame_start` is sampled at edge T, when command first reads 4'hF.
- ERASE: cycles T+1..T+16, 16 pixels, raster order dx fastest.
- MOVE: cycle T+17.
- DRAW: cycles T+18..T+33.
- IDLE: from T+34.
- Frame cost is 33 cycles. It must finish within the sequencer's ~19201-cycle Black interval and the 15 following draw steps. The next trigger therefore always arrives in IDLE during normal operation.

## Structure
- Shared package holds:
  - `CMD_BLACK` = 4'hF.
  - `BLOCK_SIZE` = 4.
  - `COLOUR_BLACK` = 3'b000.
  - VGA width constants: X 8 bits, Y 7 bits, colour 3 bits.
  - FSM state encoding.
- One sub-module, `pixel_sweep`: a 4-bit counter with `start` and `done`, emitting dx/dy. It is instantiated once and reused by ERASE and DRAW.
- Edge detect and position update stay in the top level.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with command=4'hF → plot=0, busy=0, internal x_pos=156. No frame occurs until command leaves 4'hF and returns.
- **Single frame:** command steps 0..14 then 4'hF at T, enable=1 → plot=1 with colour 000 over x 156..159 / y 60..63 during T+1..T+16. plot=0 at T+17. colour 100 over x 155..158 during T+18..T+33. busy falls at T+34.
- **Held Black:** command=4'hF for 19201 cycles → exactly one frame, 32 plot pulses in total.
- **Wrap:** run 156 frames, so x_pos=0. Next frame erases x 0..3, then draws x 156..159.
- **Trigger while busy:** raise a second Black edge at T+5 (command 4'h3 at T+4, 4'hF at T+5) → ignored. Still 32 plots total and final x_pos=155.
- **Enable and mid-frame reset:**
  - enable=0 on a Black edge → no plot, busy stays 0.
  - reset=0 sampled at T+10 → at T+11 plot=0, busy=0, x_pos=156.
